// File: rtl/dcache_sram_arb.sv
// ---------------------------------------------------------------------------
// dcache_sram_arb
//
// Controller and arbiter for the byte-enabled dcache data SRAM (simple
// dual-port, 1-cycle read latency). Three users share the single write port:
//   - the CPU load/store port (single-word read or byte-masked write),
//   - a line-refill engine streaming LINE_WORDS beats into one aligned line,
//   - a clear sequencer that zeroes the whole array (after reset or on demand).
// The read port belongs to the CPU alone. Reads are always addressed by
// cpu_addr; the grant decides whether the access counts.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata/be   CPU access request (held until cpu_gnt)
//   cpu_gnt                    combinational grant, access happens this cycle
//   cpu_rvalid/cpu_rdata       read result, one cycle after a granted read
//   rf_req/rf_addr/rf_ack      refill start handshake
//   rf_wvalid/rf_wdata         refill data beats
//   rf_wready/rf_done          refill beat acceptance / last-beat pulse
//   clr_req/clr_done           clear-array request / sweep-finished pulse
//   busy                       high in INIT, REFILL or CLEAR
//   ram_wr_*                   SRAM write port
//   ram_rd_addr/ram_rd_data    SRAM read port
// ---------------------------------------------------------------------------
module dcache_sram_arb #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int LINE_WORDS = 4,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // CPU port
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [BE_WIDTH-1:0]   cpu_be,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    // refill engine
    input  logic                  rf_req,
    input  logic [ADDR_WIDTH-1:0] rf_addr,
    output logic                  rf_ack,
    input  logic                  rf_wvalid,
    input  logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  rf_wready,
    output logic                  rf_done,
    // clear sequencer
    input  logic                  clr_req,
    output logic                  clr_done,
    output logic                  busy,
    // SRAM
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int LW_BITS   = $clog2(LINE_WORDS);
    localparam int LINE_BITS = ADDR_WIDTH - LW_BITS;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_REFILL = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    localparam state_t RST_STATE = state_t'((INIT_CLEAR != 0) ? ST_INIT : ST_IDLE);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_cnt;
    logic [ADDR_WIDTH-1:0]  w_cnt_nxt;
    logic [LINE_BITS-1:0]   r_line;
    logic [LINE_BITS-1:0]   w_line_nxt;
    logic                   r_rvalid;

    logic                   w_cnt_last;
    logic                   w_beat_last;
    logic                   w_cpu_rd;
    logic                   w_cpu_wr;
    logic [LINE_BITS-1:0]   w_cpu_line;
    logic [LINE_BITS-1:0]   w_rf_line;

    logic                   w_gnt;
    logic                   w_rf_ack;
    logic                   w_rf_wready;
    logic                   w_rf_done;
    logic                   w_clr_done;
    logic                   w_busy;
    logic                   w_wr_en;
    logic [ADDR_WIDTH-1:0]  w_wr_addr;
    logic [DATA_WIDTH-1:0]  w_wr_data;
    logic [BE_WIDTH-1:0]    w_wr_be;

    // Offset bits of rf_addr are dropped: the refill always covers the whole line.
    logic                   w_unused_rf_offset;
    assign w_unused_rf_offset = ^rf_addr[LW_BITS-1:0];

    assign w_cnt_last  = (r_cnt == {ADDR_WIDTH{1'b1}});
    assign w_beat_last = (r_cnt[LW_BITS-1:0] == LW_BITS'(LINE_WORDS - 1));
    assign w_cpu_rd    = cpu_req & ~cpu_we;
    assign w_cpu_wr    = cpu_req &  cpu_we;
    assign w_cpu_line  = cpu_addr[ADDR_WIDTH-1:LW_BITS];
    assign w_rf_line   = rf_addr[ADDR_WIDTH-1:LW_BITS];

    // State register with sweep/beat counter and latched refill line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
            r_cnt   <= {ADDR_WIDTH{1'b0}};
            r_line  <= {LINE_BITS{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_line  <= w_line_nxt;
        end
    end

    // Next-state logic: sweep progress, refill beat counting, IDLE arbitration.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_line_nxt  = r_line;
        case (r_state)
            ST_INIT, ST_CLEAR: begin
                if (w_cnt_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {ADDR_WIDTH{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (rf_req) begin
                    w_state_nxt = ST_REFILL;
                    w_cnt_nxt   = {ADDR_WIDTH{1'b0}};
                    w_line_nxt  = w_rf_line;
                end else if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = {ADDR_WIDTH{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REFILL: begin
                // Gaps (rf_wvalid=0) simply hold the counter.
                if (rf_wvalid) begin
                    if (w_beat_last) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = {ADDR_WIDTH{1'b0}};
                    end else begin
                        w_cnt_nxt   = r_cnt + ADDR_WIDTH'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            default: begin
                w_state_nxt = RST_STATE;
                w_cnt_nxt   = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Output decode: CPU grant, handshake pulses and the single write-port mux.
    always_comb begin
        w_gnt       = 1'b0;
        w_rf_ack    = 1'b0;
        w_rf_wready = 1'b0;
        w_rf_done   = 1'b0;
        w_clr_done  = 1'b0;
        w_busy      = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_addr   = cpu_addr;
        w_wr_data   = cpu_wdata;
        w_wr_be     = cpu_be;
        if (!rst_n) begin
            // Everything stays quiet while reset is held, so an aborted
            // refill or sweep leaves no trailing write or done pulse.
            w_busy = (RST_STATE != ST_IDLE);
        end else begin
            case (r_state)
                ST_INIT, ST_CLEAR: begin
                    w_busy     = 1'b1;
                    w_wr_en    = 1'b1;
                    w_wr_addr  = r_cnt;
                    w_wr_data  = {DATA_WIDTH{1'b0}};
                    w_wr_be    = {BE_WIDTH{1'b1}};
                    w_clr_done = w_cnt_last;
                end
                ST_IDLE: begin
                    if (rf_req) begin
                        // A read may proceed unless it hits the line about to be overwritten.
                        w_rf_ack = 1'b1;
                        w_gnt    = w_cpu_rd & (w_cpu_line != w_rf_line);
                    end else if (clr_req) begin
                        w_gnt    = w_cpu_rd;
                    end else begin
                        w_gnt    = cpu_req;
                        w_wr_en  = w_cpu_wr;
                    end
                end
                ST_REFILL: begin
                    w_busy      = 1'b1;
                    w_rf_wready = 1'b1;
                    w_gnt       = w_cpu_rd & (w_cpu_line != r_line);
                    if (rf_wvalid) begin
                        // Aligned base: the offset field alone walks the line, no carry.
                        w_wr_en   = 1'b1;
                        w_wr_addr = {r_line, r_cnt[LW_BITS-1:0]};
                        w_wr_data = rf_wdata;
                        w_wr_be   = {BE_WIDTH{1'b1}};
                        w_rf_done = w_beat_last;
                    end else begin
                        w_wr_en   = 1'b0;
                    end
                end
                default: begin
                    w_busy = 1'b1;
                end
            endcase
        end
    end

    // Read-valid flag: one cycle after any granted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_gnt & ~cpu_we;
        end
    end

    assign cpu_gnt        = w_gnt;
    assign cpu_rvalid     = r_rvalid;
    assign cpu_rdata      = ram_rd_data;
    assign rf_ack         = w_rf_ack;
    assign rf_wready      = w_rf_wready;
    assign rf_done        = w_rf_done;
    assign clr_done       = w_clr_done;
    assign busy           = w_busy;
    assign ram_wr_en      = w_wr_en;
    assign ram_wr_addr    = w_wr_addr;
    assign ram_wr_data    = w_wr_data;
    assign ram_wr_byte_en = w_wr_be;
    assign ram_rd_addr    = cpu_addr;

endmodule

// File: tb/tb_dcache_sram_arb.sv
// ---------------------------------------------------------------------------
// Self-checking bench for dcache_sram_arb with a behavioural 512x32 SRAM.
// CPU read expectations are pushed to a queue at grant time and popped when
// cpu_rvalid appears; a shadow memory tracks what the array should hold.
// ---------------------------------------------------------------------------
module tb_dcache_sram_arb;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [BW-1:0] cpu_be;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          rf_req;
    logic [AW-1:0] rf_addr;
    logic          rf_ack, rf_wvalid;
    logic [DW-1:0] rf_wdata;
    logic          rf_wready, rf_done;
    logic          clr_req, clr_done, busy;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data, ram_rd_data;
    logic [BW-1:0] ram_wr_byte_en;

    always #5 clk = ~clk;

    dcache_sram_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .LINE_WORDS(4), .INIT_CLEAR(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .rf_req(rf_req), .rf_addr(rf_addr), .rf_ack(rf_ack), .rf_wvalid(rf_wvalid),
        .rf_wdata(rf_wdata), .rf_wready(rf_wready), .rf_done(rf_done),
        .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    // Behavioural SRAM: byte-masked write, address sampled at the edge.
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] rd_q;
    logic [DW-1:0] wr_merge;
    logic          preload;
    logic [AW-1:0] pl_addr;

    always_comb begin
        wr_merge = mem[ram_wr_addr];
        for (int b = 0; b < BW; b++) begin
            if (ram_wr_byte_en[b]) wr_merge[b*8 +: 8] = ram_wr_data[b*8 +: 8];
        end
    end

    always @(posedge clk) begin
        if (preload) mem[pl_addr] <= 32'hFFFF_FFFF;
        else if (ram_wr_en) mem[ram_wr_addr] <= wr_merge;
        rd_q <= mem[ram_rd_addr];
    end
    assign ram_rd_data = rd_q;

    // Bench state
    int            n_chk, n_err;
    logic [DW-1:0] sh [0:DEPTH-1];
    logic [DW-1:0] exp_q [$];
    logic          exp_rv;
    logic          use_tbl;
    logic [DW-1:0] tbl_exp;
    logic [AW-1:0] tb_line_base;
    int            tb_bcnt;
    int            cnt_clr_done, cnt_rf_done;
    logic          o_gnt, o_ack, o_done, o_clr, o_busy, o_wready, o_wen;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // One clock cycle: inputs are already set; check read return, sample, account.
    task automatic cyc();
        logic [DW-1:0] e;
        check("rvalid", {31'd0, cpu_rvalid}, {31'd0, exp_rv});
        if (cpu_rvalid && exp_rv && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rdata", cpu_rdata, e);
        end
        exp_rv = 1'b0;
        #1;
        o_gnt = cpu_gnt; o_ack = rf_ack; o_done = rf_done; o_clr = clr_done;
        o_busy = busy; o_wready = rf_wready; o_wen = ram_wr_en;
        if (o_gnt) begin
            if (!cpu_we) begin
                exp_q.push_back(use_tbl ? tbl_exp : sh[cpu_addr]);
                exp_rv = 1'b1;
            end else begin
                for (int b = 0; b < BW; b++)
                    if (cpu_be[b]) sh[cpu_addr][b*8 +: 8] = cpu_wdata[b*8 +: 8];
            end
        end
        if (o_ack) begin
            tb_line_base = {rf_addr[AW-1:2], 2'b00};
            tb_bcnt = 0;
        end
        if (rf_wvalid && o_wready) begin
            sh[AW'(tb_line_base + AW'(tb_bcnt))] = rf_wdata;
            tb_bcnt++;
        end
        if (o_clr) begin
            for (int i = 0; i < DEPTH; i++) sh[i] = 32'h0;
            cnt_clr_done++;
        end
        if (o_done) cnt_rf_done++;
        @(negedge clk);
    endtask

    // Single read expected to be granted in this cycle; result checked next cycle.
    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        use_tbl = 1'b1; tbl_exp = e;
        cyc();
        check("rd_gnt", {31'd0, o_gnt}, 32'd1);
        cpu_req = 1'b0; use_tbl = 1'b0;
    endtask

    task automatic wait_not_busy(input int bound, output int n);
        logic fin;
        n = 0; fin = 1'b0;
        while (!fin) begin
            cyc();
            if (!o_busy) fin = 1'b1;
            else begin
                n++;
                if (n > bound) begin check("busy_bound", n, bound); fin = 1'b1; end
            end
        end
    endtask

    task automatic wait_gnt(input int bound, output int n);
        logic fin;
        n = 0; fin = 1'b0;
        while (!fin) begin
            cyc();
            if (o_gnt) fin = 1'b1;
            else begin
                n++;
                if (n > bound) begin check("gnt_bound", n, bound); fin = 1'b1; end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, c0, d0;
        n_chk = 0; n_err = 0; exp_rv = 1'b0; use_tbl = 1'b0; tbl_exp = 32'h0;
        tb_line_base = '0; tb_bcnt = 0; cnt_clr_done = 0; cnt_rf_done = 0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        rf_req = 1'b0; rf_addr = '0; rf_wvalid = 1'b0; rf_wdata = '0; clr_req = 1'b0;
        preload = 1'b1; pl_addr = '0;
        for (int i = 0; i < DEPTH; i++) sh[i] = 32'hFFFF_FFFF;

        tbl[0]  = '{1'b1, 9'h010, 32'h1122_3344, 4'hF, 32'h0};
        tbl[1]  = '{1'b1, 9'h010, 32'hA5A5_A5A5, 4'h5, 32'h0};
        tbl[2]  = '{1'b0, 9'h010, 32'h0,         4'h0, 32'h11A5_33A5};
        tbl[3]  = '{1'b1, 9'h011, 32'hDEAD_BEEF, 4'hF, 32'h0};
        tbl[4]  = '{1'b0, 9'h011, 32'h0,         4'h0, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b0, 9'h010, 32'h0,         4'h0, 32'h11A5_33A5};
        tbl[6]  = '{1'b1, 9'h011, 32'h0,         4'h8, 32'h0};
        tbl[7]  = '{1'b0, 9'h011, 32'h0,         4'h0, 32'h00AD_BEEF};
        tbl[8]  = '{1'b0, 9'h000, 32'h0,         4'h0, 32'h0};
        tbl[9]  = '{1'b1, 9'h020, 32'hCAFE_F00D, 4'hF, 32'h0};
        tbl[10] = '{1'b0, 9'h020, 32'h0,         4'h0, 32'hCAFE_F00D};
        tbl[11] = '{1'b1, 9'h000, 32'h1234_5678, 4'hF, 32'h0};
        tbl[12] = '{1'b0, 9'h1FF, 32'h0,         4'h0, 32'h0};

        // Reset held while the SRAM is preloaded with all ones.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            pl_addr = AW'(i);
            cyc();
        end
        preload = 1'b0;
        check("rst_busy", {31'd0, o_busy}, 32'd1);
        check("rst_wr_en", {31'd0, o_wen}, 32'd0);
        check("rst_clr_done", {31'd0, o_clr}, 32'd0);

        // Power-on clear sweep.
        rst_n = 1'b1;
        c0 = cnt_clr_done;
        wait_not_busy(600, n);
        check("init_len", n, 512);
        check("init_clr_done", cnt_clr_done - c0, 1);
        rd(9'h1FF, 32'h0);
        cyc();

        // Table of IDLE CPU accesses, back to back.
        for (int i = 0; i < 13; i++) begin
            cpu_req = 1'b1; cpu_we = tbl[i].we; cpu_addr = tbl[i].addr;
            cpu_wdata = tbl[i].wdata; cpu_be = tbl[i].be;
            use_tbl = !tbl[i].we; tbl_exp = tbl[i].exp;
            cyc();
            check($sformatf("tbl%0d_gnt", i), {31'd0, o_gnt}, 32'd1);
        end
        cpu_req = 1'b0; cpu_we = 1'b0; use_tbl = 1'b0;
        cyc();

        // Refill of line 0x1FC with one gap; reads to own/other line.
        rf_req = 1'b1; rf_addr = 9'h1FE;
        cyc();
        check("rf1_ack", {31'd0, o_ack}, 32'd1);
        rf_req = 1'b0;
        rf_wvalid = 1'b1; rf_wdata = 32'hD0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h020; use_tbl = 1'b1; tbl_exp = 32'hCAFE_F00D;
        cyc();
        check("rf1_wready", {31'd0, o_wready}, 32'd1);
        check("rf1_busy", {31'd0, o_busy}, 32'd1);
        check("rf1_rd_other", {31'd0, o_gnt}, 32'd1);
        rf_wvalid = 1'b0; cpu_addr = 9'h1FD; tbl_exp = 32'hD1;
        cyc();
        check("rf1_gap_gnt", {31'd0, o_gnt}, 32'd0);
        check("rf1_gap_wr", {31'd0, o_wen}, 32'd0);
        for (int k = 1; k < 4; k++) begin
            rf_wvalid = 1'b1; rf_wdata = 32'hD0 + k;
            cyc();
            check("rf1_rd_stall", {31'd0, o_gnt}, 32'd0);
            check("rf1_done", {31'd0, o_done}, (k == 3) ? 32'd1 : 32'd0);
        end
        rf_wvalid = 1'b0;
        cyc();
        check("rf1_rd_idle", {31'd0, o_gnt}, 32'd1);
        check("rf1_idle", {31'd0, o_busy}, 32'd0);
        cpu_req = 1'b0; use_tbl = 1'b0;
        cyc();

        // Refill of line 0x030 with a CPU write stalled throughout.
        rf_req = 1'b1; rf_addr = 9'h033;
        cyc();
        check("rf2_ack", {31'd0, o_ack}, 32'd1);
        rf_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h040; cpu_wdata = 32'h0BAD_F00D; cpu_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            rf_wvalid = 1'b1; rf_wdata = 32'hE0 + k;
            cyc();
            check("rf2_wr_stall", {31'd0, o_gnt}, 32'd0);
            check("rf2_done", {31'd0, o_done}, (k == 3) ? 32'd1 : 32'd0);
        end
        rf_wvalid = 1'b0;
        cyc();
        check("rf2_wr_idle", {31'd0, o_gnt}, 32'd1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        rd(9'h040, 32'h0BAD_F00D);
        rd(9'h031, 32'hE1);
        rd(9'h1FC, 32'hD0);
        rd(9'h1FF, 32'hD3);
        rd(9'h000, 32'h1234_5678);
        rd(9'h1FB, 32'h0);
        cyc();

        // Same-cycle refill, clear and CPU write.
        rf_req = 1'b1; rf_addr = 9'h081; clr_req = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h050; cpu_wdata = 32'h7777_7777; cpu_be = 4'hF;
        cyc();
        check("pri_ack", {31'd0, o_ack}, 32'd1);
        check("pri_wr_gnt", {31'd0, o_gnt}, 32'd0);
        rf_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rf_wvalid = 1'b1; rf_wdata = 32'hF0 + k;
            cyc();
            check("pri_wr_stall", {31'd0, o_gnt}, 32'd0);
            check("pri_done", {31'd0, o_done}, (k == 3) ? 32'd1 : 32'd0);
        end
        rf_wvalid = 1'b0;
        cyc();
        check("pri_clr_over_wr", {31'd0, o_gnt}, 32'd0);
        check("pri_clr_idle", {31'd0, o_busy}, 32'd0);
        clr_req = 1'b0;
        c0 = cnt_clr_done;
        wait_gnt(600, n);
        check("clr_len", n, 512);
        check("clr_done_cnt", cnt_clr_done - c0, 1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        rd(9'h050, 32'h7777_7777);
        rd(9'h080, 32'h0);
        rd(9'h082, 32'h0);
        rd(9'h010, 32'h0);
        cyc();

        // Reset dropped in the second refill beat.
        rf_req = 1'b1; rf_addr = 9'h100;
        cyc();
        check("rst_rf_ack", {31'd0, o_ack}, 32'd1);
        rf_req = 1'b0;
        rf_wvalid = 1'b1; rf_wdata = 32'hA0;
        cyc();
        d0 = cnt_rf_done;
        rf_wdata = 32'hA1; rst_n = 1'b0;
        cyc();
        check("abort_wr_en", {31'd0, o_wen}, 32'd0);
        check("abort_done", {31'd0, o_done}, 32'd0);
        check("abort_busy", {31'd0, o_busy}, 32'd1);
        rf_wvalid = 1'b0;
        cyc();
        rst_n = 1'b1;
        c0 = cnt_clr_done;
        wait_not_busy(600, n);
        check("reinit_len", n, 512);
        check("reinit_clr_done", cnt_clr_done - c0, 1);
        check("abort_no_rf_done", cnt_rf_done - d0, 0);
        rd(9'h100, 32'h0);
        rd(9'h101, 32'h0);
        cyc();
        cyc();

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
